// File: rtl/instr_packer_pkg.sv
// Shared definitions for the instruction packer: format codes (same encoding
// as the sign-extend unit), immediate range limits, the request record held
// in the first pipeline stage, and small range-check helpers.
package instr_packer_pkg;

  // Format selector, identical to the sign-extend unit's SEU encoding.
  typedef enum logic [1:0] {
    FMT_I  = 2'd0,
    FMT_D  = 2'd1,
    FMT_B  = 2'd2,
    FMT_CB = 2'd3
  } fmt_e;

  // Width of one packed instruction word.
  localparam int INSN_W = 32;

  // Inclusive signed limits of the value each format can carry.
  localparam logic signed [63:0] IMM_MIN   = 64'sd0;
  localparam logic signed [63:0] IMM12_MAX = 64'sd4095;
  localparam logic signed [63:0] ADDR9_MAX = 64'sd511;
  localparam logic signed [63:0] B_MIN     = -64'sd134217728;  // -2^27
  localparam logic signed [63:0] B_MAX     = 64'sd134217724;   // 2^27-4
  localparam logic signed [63:0] CB_MIN    = -64'sd1048576;    // -2^20
  localparam logic signed [63:0] CB_MAX    = 64'sd1048572;     // 2^20-4

  // One accepted request as registered in stage 1.
  typedef struct packed {
    fmt_e        fmt;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [63:0] value;
  } pack_req_t;

  // Signed inclusive range test on a 64-bit value.
  function automatic logic in_range(input logic signed [63:0] v,
                                    input logic signed [63:0] lo,
                                    input logic signed [63:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Branch offsets must address whole 4-byte instructions.
  function automatic logic word_aligned(input logic [63:0] v);
    return (v[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_field_enc.sv
// Combinational format mux and range check. Packs the immediate back into
// its instruction field and flags whether the value fits that field.
module instr_field_enc
  import instr_packer_pkg::*;
(
  input  logic [1:0]        i_fmt,
  input  logic [10:0]       i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rn,
  input  logic [63:0]       i_value,
  output logic [INSN_W-1:0] o_word,
  output logic              o_ok
);

  // Select the field layout for the format and check the value's range.
  always_comb begin
    o_word = 32'h0000_0000;
    o_ok   = 1'b0;
    case (i_fmt)
      FMT_I: begin
        o_word = {i_opcode[10:1], i_value[11:0], i_rn, i_rd};
        o_ok   = in_range(i_value, IMM_MIN, IMM12_MAX);
      end
      FMT_D: begin
        o_word = {i_opcode[10:0], i_value[8:0], 2'b00, i_rn, i_rd};
        o_ok   = in_range(i_value, IMM_MIN, ADDR9_MAX);
      end
      FMT_B: begin
        o_word = {i_opcode[10:5], i_value[27:2]};
        o_ok   = word_aligned(i_value) && in_range(i_value, B_MIN, B_MAX);
      end
      FMT_CB: begin
        o_word = {i_opcode[10:3], i_value[20:2], i_rd};
        o_ok   = word_aligned(i_value) && in_range(i_value, CB_MIN, CB_MAX);
      end
      default: begin
        o_word = 32'h0000_0000;
        o_ok   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: two-stage pipeline that range-checks and packs
// instruction descriptions, then streams the words to instruction memory at
// consecutive addresses. Rejected requests are dropped in stage 2 and logged
// in the sticky error registers.
module instr_packer
  import instr_packer_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_SEU,
  input  logic [10:0]       i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rn,
  input  logic [63:0]       i_value,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Stage 1: accepted request.
  logic              r_s1_full;
  pack_req_t         r_s1_req;
  // Stage 2: encoded word; valid and rejected are mutually exclusive.
  logic              r_s2_valid;
  logic              r_s2_rej;
  logic [1:0]        r_s2_fmt;
  logic [31:0]       r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;
  // Sticky error capture.
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [ADDR_W-1:0] r_err_addr;
  logic [CNT_W-1:0]  r_err_cnt;

  // Handshake and next-state terms.
  logic              w_wr_fire;
  logic              w_s2_free;
  logic              w_ready;
  logic              w_accept;
  logic              w_s1_move;
  logic [31:0]       w_enc_word;
  logic              w_enc_ok;
  logic              w_s1_full_nxt;
  pack_req_t         w_s1_req_nxt;
  logic              w_s2_valid_nxt;
  logic              w_s2_rej_nxt;
  logic [1:0]        w_s2_fmt_nxt;
  logic [31:0]       w_wr_data_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic              w_err_nxt;
  logic [1:0]        w_err_code_nxt;
  logic [ADDR_W-1:0] w_err_addr_nxt;
  logic [CNT_W-1:0]  w_err_cnt_nxt;

  // Format mux and range check sit between stage 1 and stage 2.
  instr_field_enc u_enc (
    .i_fmt    (r_s1_req.fmt),
    .i_opcode (r_s1_req.opcode),
    .i_rd     (r_s1_req.rd),
    .i_rn     (r_s1_req.rn),
    .i_value  (r_s1_req.value),
    .o_word   (w_enc_word),
    .o_ok     (w_enc_ok)
  );

  // Handshake: stage 2 frees up when empty, rejected, or being written.
  always_comb begin
    w_wr_fire = r_s2_valid & i_wr_ready;
    w_s2_free = ~r_s2_valid | w_wr_fire;
    w_ready   = ~i_start & (~r_s1_full | w_s2_free);
    w_accept  = i_valid & w_ready;
    w_s1_move = r_s1_full & w_s2_free;
  end

  // Next-state for pipeline, address counter and error capture; i_start wins.
  always_comb begin
    w_s1_full_nxt  = r_s1_full;
    w_s1_req_nxt   = r_s1_req;
    w_s2_valid_nxt = r_s2_valid;
    w_s2_rej_nxt   = r_s2_rej;
    w_s2_fmt_nxt   = r_s2_fmt;
    w_wr_data_nxt  = r_wr_data;
    w_wr_addr_nxt  = r_wr_addr;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;
    w_err_addr_nxt = r_err_addr;
    w_err_cnt_nxt  = r_err_cnt;
    if (i_start) begin
      w_s1_full_nxt  = 1'b0;
      w_s2_valid_nxt = 1'b0;
      w_s2_rej_nxt   = 1'b0;
      w_wr_addr_nxt  = i_base_addr;
      w_err_nxt      = 1'b0;
      w_err_code_nxt = 2'b00;
      w_err_addr_nxt = {ADDR_W{1'b0}};
      w_err_cnt_nxt  = {CNT_W{1'b0}};
    end else begin
      // Stage 1 loads on accept, otherwise empties once its entry moves on.
      if (w_accept) begin
        w_s1_full_nxt       = 1'b1;
        w_s1_req_nxt.fmt    = fmt_e'(i_SEU);
        w_s1_req_nxt.opcode = i_opcode;
        w_s1_req_nxt.rd     = i_rd;
        w_s1_req_nxt.rn     = i_rn;
        w_s1_req_nxt.value  = i_value;
      end else if (w_s1_move) begin
        w_s1_full_nxt = 1'b0;
      end else begin
        w_s1_full_nxt = r_s1_full;
      end

      // Stage 2 takes the encoded word; a rejected entry lives one cycle.
      if (w_s1_move) begin
        w_s2_valid_nxt = w_enc_ok;
        w_s2_rej_nxt   = ~w_enc_ok;
        w_s2_fmt_nxt   = r_s1_req.fmt;
        w_wr_data_nxt  = w_enc_word;
      end else if (w_wr_fire || r_s2_rej) begin
        w_s2_valid_nxt = 1'b0;
        w_s2_rej_nxt   = 1'b0;
      end else begin
        w_s2_valid_nxt = r_s2_valid;
        w_s2_rej_nxt   = r_s2_rej;
      end

      // Address advances only on a completed write; wraps silently.
      if (w_wr_fire) begin
        w_wr_addr_nxt = r_wr_addr + ADDR_STEP;
      end else begin
        w_wr_addr_nxt = r_wr_addr;
      end

      // A rejected entry bumps the counter and, if first, records its context.
      if (r_s2_rej) begin
        if (r_err_cnt != CNT_MAX) begin
          w_err_cnt_nxt = r_err_cnt + CNT_ONE;
        end else begin
          w_err_cnt_nxt = r_err_cnt;
        end
        if (!r_err) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = r_s2_fmt;
          w_err_addr_nxt = r_wr_addr;
        end else begin
          w_err_nxt = r_err;
        end
      end else begin
        w_err_cnt_nxt = r_err_cnt;
      end
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_full  <= 1'b0;
      r_s1_req   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_rej   <= 1'b0;
      r_s2_fmt   <= 2'b00;
      r_wr_data  <= 32'h0000_0000;
      r_wr_addr  <= {ADDR_W{1'b0}};
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_err_addr <= {ADDR_W{1'b0}};
      r_err_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_s1_full  <= w_s1_full_nxt;
      r_s1_req   <= w_s1_req_nxt;
      r_s2_valid <= w_s2_valid_nxt;
      r_s2_rej   <= w_s2_rej_nxt;
      r_s2_fmt   <= w_s2_fmt_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // Output mapping.
  always_comb begin
    o_ready    = w_ready;
    o_wr_valid = r_s2_valid;
    o_wr_addr  = r_wr_addr;
    o_wr_data  = r_wr_data;
    o_err      = r_err;
    o_err_code = r_err_code;
    o_err_addr = r_err_addr;
    o_err_cnt  = r_err_cnt;
  end

endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Inverse of the processor's immediate sign-extend stage. Takes an instruction description (opcode, registers, format selector, 64-bit immediate value) and range-checks the value for the selected format.
- Packs the value back into the 32-bit ARMv8/LEGv8 instruction fields.
- Streams the resulting words into instruction memory at consecutive addresses.
- Used by the boot/program loader ahead of the fetch stage.

Parameters:
- ADDR_W, 64, width of instruction-memory write address.
- CNT_W, 16, width of the error counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_start  in  1  pulse: load address, clear errors, flush pipeline.
- i_base_addr  in  ADDR_W  start address, sampled on i_start.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid && o_ready.
- i_SEU  in  2  format: 0=I, 1=D, 2=B, 3=CB (same encoding as the sign-extend unit).
- i_opcode  in  11  opcode, MSB-aligned: I uses [10:1], D uses [10:0], B uses [10:5], CB uses [10:3].
- i_rd  in  5  Rd/Rt field.
- i_rn  in  5  Rn field.
- i_value  in  64  signed immediate or byte offset.
- o_wr_valid  out  1  write word valid.
- i_wr_ready  in  1  memory accepts the word when o_wr_valid && i_wr_ready.
- o_wr_addr  out  ADDR_W  byte address of the word.
- o_wr_data  out  32  packed instruction.
- o_err  out  1  sticky: any request was rejected since the last i_start or reset.
- o_err_code  out  2  format of the first rejected request.
- o_err_addr  out  ADDR_W  address the first rejected request would have used.
- o_err_cnt  out  CNT_W  number of rejected requests; saturates at all-ones.

Behaviour:
- Reset values (async, on i_rst_n low): o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_err=0, o_err_code=0, o_err_addr=0, o_err_cnt=0, both pipeline stages empty, o_ready=1.
- Pipeline has 2 stages:
  - S1 registers the accepted request.
  - S2 holds the encoded word and the check result. S2 is the output register.
  - Latency: a request accepted at edge N presents on o_wr_* after edge N+1, provided there is no stall.
  - o_ready = !S1_full || (S2 will be free this cycle), where S2 is free if it is empty, holds a rejected entry, or is being consumed (i_wr_ready).
  - Full throughput is 1 word per cycle while i_wr_ready stays high.
- Range rules:
  - I: 0 ≤ value ≤ 4095. Word = {op[10:1], value[11:0], rn, rd}.
  - D: 0 ≤ value ≤ 511. Word = {op[10:0], value[8:0], 2'b00, rn, rd}.
  - B: value[1:0] must be 0, and -2^27 ≤ value ≤ 2^27-4. Word = {op[10:5], value[27:2]}.
  - CB: value[1:0] must be 0, and -2^20 ≤ value ≤ 2^20-4. Word = {op[10:3], value[20:2], rd}.
  - All comparisons are signed 64-bit.
- Rejected request:
  - It reaches S2 but never asserts o_wr_valid; it is dropped in one cycle.
  - o_wr_addr does not advance.
  - o_err_cnt increments (saturating).
  - If o_err was 0: o_err goes to 1, and o_err_code and o_err_addr are captured.
- Address:
  - o_wr_addr is the address of the word in S2.
  - After each completed write handshake it advances by 4.
  - Wrap-around is modulo 2^ADDR_W with no flag.
- While o_wr_valid=1 and i_wr_ready=0, o_wr_addr and o_wr_data hold stable.
- i_start:
  - Takes priority over every other event.
  - Next cycle: both stages are empty, any in-flight words are discarded without being written, o_wr_addr = i_base_addr, and all error outputs are 0.
  - A request presented in the same cycle as i_start is not accepted: o_ready=0 in that cycle.
- Reset mid-stream: all state clears immediately. There is no partial write; o_wr_valid drops asynchronously.
- Inputs are ignored while o_ready=0.

Decomposition:
- Shared package holds:
  - format constants FMT_I=0, FMT_D=1, FMT_B=2, FMT_CB=3, shared with the sign-extend unit;
  - field-position and limit constants (IMM12_MAX=4095, ADDR9_MAX=511, B_MIN/B_MAX, CB_MIN/CB_MAX).
- Sub-module instr_field_enc: purely combinational format mux plus range check, outputs {word, ok}. It is instantiated between S1 and S2.
- Address counter, error capture and handshake logic live in the top module.

Test Plan:
- i_start with base 0x100, then I-type op=11'h488, rn=1, rd=2, value=5 → o_wr_valid the cycle after the S1 register, addr 0x100, data 0x91001422.
- Back-to-back requests, i_wr_ready=1:
  - D op=11'h7C2, rn=1, rd=2, value=8 → 0xF8408022 at 0x100.
  - B op=11'h0A0, value=-8 → 0x17FFFFFE at 0x104.
  - CB op=11'h5A0, rd=3, value=16 → 0xB4000083 at 0x108.
  - One word per cycle throughout.
- Range errors:
  - I value=4096 → no write, o_err=1, o_err_code=0, o_err_addr=0x10C, o_err_cnt=1.
  - Then B value=6 (misaligned) → rejected, o_err_cnt=2, code still 0.
  - Next valid word still goes to 0x10C.
- Backpressure: hold i_wr_ready=0 for 5 cycles with 3 requests offered → o_ready falls once S1 and S2 are full, o_wr_data is stable, no loss or duplication, addresses are consecutive after release.
- i_start while both stages are full → in-flight words are never written, o_wr_addr = new base, errors cleared; also check the boundary values 4095, 511, 2^27-4, -2^20, which must all be accepted.
- Async reset asserted between clock edges during a stalled write → o_wr_valid=0 immediately, all outputs at reset values.
